// File: rtl/motor_move_ctrl_pkg.sv
// rtl/motor_move_ctrl_pkg.sv - shared FSM state and termination status encodings for the move controller
package MotorCtrlPkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    HIGH,
    LOW,
    FINISH
  } state_t;

  typedef enum logic [2:0] {
    STATUS_OK       = 3'd0,
    STATUS_SWITCH   = 3'd1,
    STATUS_FAIL     = 3'd2,
    STATUS_OVERHEAT = 3'd3,
    STATUS_ABORT    = 3'd4
  } status_t;

endpackage

// File: rtl/motor_move_ctrl_sync.sv
// rtl/motor_move_ctrl_sync.sv - two-flop synchronizer with a per-bit reset value
module sync_2ff #(
  parameter int                 g_Width      = 1,
  parameter logic [g_Width-1:0] g_ResetValue = '0
) (
  input  logic               Clk_ik,
  input  logic               Rst_ir,
  input  logic [g_Width-1:0] Async_ib,
  output logic [g_Width-1:0] Sync_ob
);

  logic [g_Width-1:0] meta;

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      meta    <= g_ResetValue;
      Sync_ob <= g_ResetValue;
    end else begin
      meta    <= Async_ib;
      Sync_ob <= meta;
    end
  end

endmodule

// File: rtl/motor_move_ctrl.sv
// rtl/motor_move_ctrl.sv - stepper move sequencer: settle, step pulse train, limit/fault termination
module motor_move_ctrl
  import MotorCtrlPkg::*;
#(
  parameter int g_CountBits    = 16,
  parameter int g_PeriodBits   = 16,
  parameter int g_SettleCycles = 8
) (
  input  logic                    Clk_ik,
  input  logic                    Rst_ir,
  input  logic                    Start_i,
  input  logic                    Dir_i,
  input  logic                    Boost_i,
  input  logic [g_CountBits-1:0]  StepCount_ib,
  input  logic [g_PeriodBits-1:0] HalfPeriod_ib,
  input  logic                    Abort_i,
  input  logic [1:0]              Switches_ib,
  input  logic                    StepPFail_i,
  input  logic                    OH_i,
  output logic                    StepOutP_o,
  output logic                    StepDIR_o,
  output logic                    StepENAB_o,
  output logic                    StepBOOST_o,
  output logic                    Busy_o,
  output logic                    Done_o,
  output logic [2:0]              Status_ob,
  output logic [g_CountBits-1:0]  StepsDone_ob
);

  localparam int SettleBits = $clog2(g_SettleCycles + 1);
  localparam int TimerBits  = (g_PeriodBits > SettleBits) ? g_PeriodBits : SettleBits;
  localparam logic [TimerBits-1:0] SettleLoad = TimerBits'(g_SettleCycles - 1);

  state_t                 state, nextState;
  status_t                cause, nextCause;
  logic [TimerBits-1:0]   timer;
  logic [TimerBits-1:0]   halfLoad;
  logic [g_CountBits-1:0] countL;
  logic                   boostL;
  logic [3:0]             syncIn, syncOut;
  logic                   failS, ohS, dirSwitchOk, runNext;

  // Switch inputs reset to 1 (released), fault inputs to 0.
  assign syncIn = {StepPFail_i, OH_i, Switches_ib};

  sync_2ff #(
    .g_Width     (4),
    .g_ResetValue(4'b0011)
  ) i_sync (
    .Clk_ik  (Clk_ik),
    .Rst_ir  (Rst_ir),
    .Async_ib(syncIn),
    .Sync_ob (syncOut)
  );

  assign failS       = syncOut[3];
  assign ohS         = syncOut[2];
  assign dirSwitchOk = StepDIR_o ? syncOut[0] : syncOut[1];

  always_comb begin
    nextState = state;
    nextCause = cause;
    case (state)
      IDLE: if (Start_i) nextState = SETTLE;
      SETTLE, HIGH, LOW: begin
        if (failS) begin
          nextState = FINISH;
          nextCause = STATUS_FAIL;
        end else if (ohS) begin
          nextState = FINISH;
          nextCause = STATUS_OVERHEAT;
        end else if (Abort_i) begin
          nextState = FINISH;
          nextCause = STATUS_ABORT;
        end else if (timer == '0) begin
          if (state == HIGH) begin
            nextState = LOW;
          end else if (StepsDone_ob == countL) begin
            // Also covers a zero-step move leaving SETTLE, since StepsDone is 0 there.
            nextState = FINISH;
            nextCause = STATUS_OK;
          end else if (!dirSwitchOk) begin
            nextState = FINISH;
            nextCause = STATUS_SWITCH;
          end else begin
            nextState = HIGH;
          end
        end
      end
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign runNext = (nextState == SETTLE) || (nextState == HIGH) || (nextState == LOW);

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      state        <= IDLE;
      cause        <= STATUS_OK;
      timer        <= '0;
      halfLoad     <= '0;
      countL       <= '0;
      boostL       <= 1'b0;
      StepOutP_o   <= 1'b0;
      StepDIR_o    <= 1'b0;
      StepENAB_o   <= 1'b1;
      StepBOOST_o  <= 1'b0;
      Busy_o       <= 1'b0;
      Done_o       <= 1'b0;
      Status_ob    <= 3'd0;
      StepsDone_ob <= '0;
    end else begin
      state <= nextState;
      cause <= nextCause;

      if (nextState != state) begin
        case (nextState)
          SETTLE:    timer <= SettleLoad;
          HIGH, LOW: timer <= halfLoad;
          default:   timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (state == IDLE && Start_i) begin
        StepDIR_o    <= Dir_i;
        boostL       <= Boost_i;
        countL       <= StepCount_ib;
        halfLoad     <= (HalfPeriod_ib == '0) ? '0 : TimerBits'(HalfPeriod_ib - 1'b1);
        StepsDone_ob <= '0;
      end else if (nextState == HIGH && state != HIGH) begin
        StepsDone_ob <= StepsDone_ob + 1'b1;
      end

      StepOutP_o  <= (nextState == HIGH);
      StepENAB_o  <= !runNext;
      StepBOOST_o <= runNext && ((state == IDLE) ? Boost_i : boostL);
      Busy_o      <= (nextState != IDLE);
      Done_o      <= (state == FINISH);
      if (state == FINISH) Status_ob <= cause;
    end
  end

endmodule

// File: tb/tb_motor_move_ctrl.sv
// tb/tb_motor_move_ctrl.sv - directed self-checking bench for motor_move_ctrl with a simple position model
module tb_motor_move_ctrl;

  logic        clk_k = 1'b0;
  logic        Rst_ir = 1'b1;
  logic        Start_i = 1'b0, Dir_i = 1'b0, Boost_i = 1'b0, Abort_i = 1'b0;
  logic [15:0] StepCount_ib = '0, HalfPeriod_ib = '0;
  logic        StepPFail_i = 1'b0, OH_i = 1'b0;
  logic [1:0]  switches;
  logic        StepOutP_o, StepDIR_o, StepENAB_o, StepBOOST_o, Busy_o, Done_o;
  logic [2:0]  Status_ob;
  logic [15:0] StepsDone_ob;

  int checks = 0, errors = 0;
  int cyc = 0, pos = 0, pulses = 0, firstRise = -1, startCyc = 0, runLen = 0;
  int hiMin = 9999, hiMax = 0, loMin = 9999, loMax = 0, doneHits;
  logic prevStep = 1'b0;
  logic [31:0] expRst;

  always #5 clk_k = ~clk_k;

  // Limit switches are active-low: switch 0 at the positive end, switch 1 far negative.
  assign switches = {(pos <= -20) ? 1'b0 : 1'b1, (pos >= 12) ? 1'b0 : 1'b1};

  motor_move_ctrl dut (
    .Clk_ik(clk_k), .Rst_ir(Rst_ir), .Start_i(Start_i), .Dir_i(Dir_i), .Boost_i(Boost_i),
    .StepCount_ib(StepCount_ib), .HalfPeriod_ib(HalfPeriod_ib), .Abort_i(Abort_i),
    .Switches_ib(switches), .StepPFail_i(StepPFail_i), .OH_i(OH_i),
    .StepOutP_o(StepOutP_o), .StepDIR_o(StepDIR_o), .StepENAB_o(StepENAB_o),
    .StepBOOST_o(StepBOOST_o), .Busy_o(Busy_o), .Done_o(Done_o),
    .Status_ob(Status_ob), .StepsDone_ob(StepsDone_ob)
  );

  always @(posedge clk_k) cyc <= cyc + 1;

  always @(negedge clk_k) begin
    prevStep <= StepOutP_o;
    if (Start_i && !Busy_o) begin
      pulses <= 0; firstRise <= -1; startCyc <= cyc; runLen <= 0;
      hiMin <= 9999; hiMax <= 0; loMin <= 9999; loMax <= 0;
    end else if (StepOutP_o && !prevStep) begin
      pulses <= pulses + 1;
      pos <= pos + (StepDIR_o ? 1 : -1);
      if (firstRise < 0) firstRise <= cyc;
      if (pulses > 0) begin
        if (runLen < loMin) loMin <= runLen;
        if (runLen > loMax) loMax <= runLen;
      end
      runLen <= 1;
    end else if (!StepOutP_o && prevStep) begin
      if (runLen < hiMin) hiMin <= runLen;
      if (runLen > hiMax) hiMax <= runLen;
      runLen <= 1;
    end else begin
      runLen <= runLen + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic startMove(input logic dir, input logic boost, input logic [15:0] count,
                           input logic [15:0] half);
    @(posedge clk_k); #1;
    Dir_i = dir; Boost_i = boost; StepCount_ib = count; HalfPeriod_ib = half; Start_i = 1'b1;
    @(posedge clk_k); #1;
    Start_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_k);
      n++;
    end while (!Done_o && n < budget);
    chk(tag, {31'd0, Done_o}, 32'd1);
  endtask

  task automatic waitPulses(input string tag, input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk_k); #1;
      n++;
    end while (pulses != target && n < 2000);
    chk(tag, pulses, target);
  endtask

  initial begin
    expRst = {7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
    repeat (3) @(negedge clk_k);
    chk("reset_outputs", {7'd0, StepOutP_o, StepDIR_o, StepENAB_o, StepBOOST_o, Busy_o, Done_o,
                          Status_ob, StepsDone_ob}, expRst);
    @(posedge clk_k); #1; Rst_ir = 1'b0;
    repeat (3) @(posedge clk_k);

    // Ten full steps upward
    startMove(1'b1, 1'b1, 16'd10, 16'd50);
    @(negedge clk_k);
    chk("settle_outputs", {27'd0, Busy_o, StepENAB_o, StepDIR_o, StepBOOST_o, StepOutP_o}, 32'b10110);
    waitDone("t1_done", 3000);
    chk("t1_status", Status_ob, 0);
    chk("t1_steps", StepsDone_ob, 10);
    chk("t1_pulses", pulses, 10);
    chk("t1_first_edge", firstRise - startCyc, 9);
    chk("t1_hi_min", hiMin, 50);
    chk("t1_hi_max", hiMax, 50);
    chk("t1_lo_min", loMin, 50);
    chk("t1_lo_max", loMax, 50);
    @(negedge clk_k);
    chk("t1_idle_outputs", {28'd0, Busy_o, Done_o, StepENAB_o, StepBOOST_o}, 32'b0010);

    // Run into the positive limit switch
    startMove(1'b1, 1'b0, 16'd5, 16'd50);
    waitDone("t2_done", 3000);
    chk("t2_status", Status_ob, 1);
    chk("t2_steps", StepsDone_ob, 2);
    chk("t2_pulses", pulses, 2);
    repeat (5) @(negedge clk_k);
    chk("t2_status_hold", Status_ob, 1);
    chk("t2_steps_hold", StepsDone_ob, 2);

    // Back off the limit: the opposite switch is ignored
    startMove(1'b0, 1'b0, 16'd3, 16'd50);
    waitDone("t3_done", 3000);
    chk("t3_status", Status_ob, 0);
    chk("t3_steps", StepsDone_ob, 3);
    chk("t3_pulses", pulses, 3);

    // Zero-step move
    startMove(1'b1, 1'b0, 16'd0, 16'd50);
    waitDone("t4_done", 100);
    chk("t4_done_latency", cyc - startCyc, 10);
    chk("t4_status", Status_ob, 0);
    chk("t4_steps", StepsDone_ob, 0);
    chk("t4_pulses", pulses, 0);

    // Overheat and abort effective together in HIGH of step 4 (OH raised early for sync latency)
    startMove(1'b0, 1'b0, 16'd10, 16'd50);
    waitPulses("t5_reach_step4", 4);
    repeat (10) @(posedge clk_k);
    #1; OH_i = 1'b1;
    repeat (2) @(posedge clk_k);
    #1; Abort_i = 1'b1;
    @(negedge clk_k);
    chk("t5_still_high", {31'd0, StepOutP_o}, 1);
    @(negedge clk_k);
    chk("t5_pulse_cut", {31'd0, StepOutP_o}, 0);
    @(posedge clk_k); #1; Abort_i = 1'b0; OH_i = 1'b0;
    waitDone("t5_done", 100);
    chk("t5_status", Status_ob, 3);
    chk("t5_steps", StepsDone_ob, 4);

    // Driver fail beats abort
    startMove(1'b0, 1'b0, 16'd5, 16'd5);
    waitPulses("t8_reach_step1", 1);
    @(posedge clk_k); #1; StepPFail_i = 1'b1;
    repeat (2) @(posedge clk_k);
    #1; Abort_i = 1'b1;
    @(negedge clk_k);
    chk("t8_still_high", {31'd0, StepOutP_o}, 1);
    @(negedge clk_k);
    chk("t8_pulse_cut", {31'd0, StepOutP_o}, 0);
    @(posedge clk_k); #1; Abort_i = 1'b0; StepPFail_i = 1'b0;
    waitDone("t8_done", 100);
    chk("t8_status", Status_ob, 2);
    chk("t8_steps", StepsDone_ob, 1);

    // Reset during LOW of step 2
    startMove(1'b1, 1'b1, 16'd5, 16'd50);
    waitPulses("t6_reach_step2", 2);
    repeat (60) @(posedge clk_k);
    #1; Rst_ir = 1'b1;
    #1;
    chk("t6_async_reset", {7'd0, StepOutP_o, StepDIR_o, StepENAB_o, StepBOOST_o, Busy_o, Done_o,
                           Status_ob, StepsDone_ob}, expRst);
    repeat (2) @(posedge clk_k);
    #1; Rst_ir = 1'b0;
    doneHits = 0;
    repeat (20) begin
      @(negedge clk_k);
      if (Done_o) doneHits++;
    end
    chk("t6_no_done", doneHits, 0);

    // Move after reset, with a second Start ignored mid-move
    startMove(1'b1, 1'b0, 16'd2, 16'd3);
    repeat (4) @(posedge clk_k);
    startMove(1'b1, 1'b0, 16'd7, 16'd9);
    waitDone("t6b_done", 200);
    chk("t6b_status", Status_ob, 0);
    chk("t6b_steps", StepsDone_ob, 2);
    chk("t6b_pulses", pulses, 2);
    chk("t6b_hi", hiMax, 3);
    chk("t6b_lo", loMin, 3);

    // HalfPeriod of zero behaves as one
    startMove(1'b0, 1'b0, 16'd2, 16'd0);
    waitDone("t7_done", 100);
    chk("t7_steps", StepsDone_ob, 2);
    chk("t7_hi_max", hiMax, 1);
    chk("t7_lo_max", loMax, 1);
    chk("t7_hi_min", hiMin, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
